// File: rtl/mini_spi_pkg.sv
// Shared types and default parameters for the Mini SPI initiator.
package mini_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  localparam int unsigned MINI_SPI_DEFAULT_WIDTH   = 8;
  localparam int unsigned MINI_SPI_DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, left-shifting register: serial in at LSB, serial out at MSB.
module spi_shift_reg
  import mini_spi_pkg::*;
#(
  parameter int unsigned WIDTH = MINI_SPI_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/spi_controller.sv
// Mini SPI initiator, mode 0, MSB-first full-duplex frames.
// Build option MINI_SPI_LOOPBACK_EN: receive path samples internal mosi instead of miso.
module spi_controller
  import mini_spi_pkg::*;
#(
  parameter int unsigned WIDTH   = MINI_SPI_DEFAULT_WIDTH,
  parameter int unsigned CLK_DIV = MINI_SPI_DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

  spi_state_t       state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] tx_par_unused;
  logic             rx_ser_unused;

  logic             accept_c;
  logic             half_end_c;
  logic             rise_c;
  logic             fall_c;
  logic             tx_load_c;
  logic             tx_shift_c;
  logic [WIDTH-1:0] tx_load_data_c;
  logic             rx_in_c;

  // Edge strobes: a rise ends SETUP or a low half-period; no rise after the last bit.
  assign accept_c       = start && ((state == IDLE) || (state == DONE));
  assign half_end_c     = (div_cnt == '0);
  assign rise_c         = half_end_c && ((state == SETUP) ||
                          ((state == SHIFT) && !sclk && (bit_cnt != BIT_LAST)));
  assign fall_c         = half_end_c && (state == SHIFT) && sclk;
  assign tx_shift_c     = fall_c && (bit_cnt != BIT_LAST);
  assign tx_load_c      = accept_c || ((state == HOLD) && half_end_c);
  assign tx_load_data_c = accept_c ? tx_data : '0;

`ifdef MINI_SPI_LOOPBACK_EN
  logic miso_unused;
  assign miso_unused = miso;
  assign rx_in_c     = mosi;
`else
  assign rx_in_c     = miso;
`endif

  // TX register MSB drives mosi directly; it is zeroed whenever cs_n goes high.
  spi_shift_reg #(.WIDTH(WIDTH)) u_tx (
    .clk        (clk),
    .clear_n    (clear_n),
    .load       (tx_load_c),
    .load_data  (tx_load_data_c),
    .shift_en   (tx_shift_c),
    .serial_in  (1'b0),
    .q          (tx_par_unused),
    .serial_out (mosi)
  );

  spi_shift_reg #(.WIDTH(WIDTH)) u_rx (
    .clk        (clk),
    .clear_n    (clear_n),
    .load       (1'b0),
    .load_data  ('0),
    .shift_en   (rise_c),
    .serial_in  (rx_in_c),
    .q          (rx_q),
    .serial_out (rx_ser_unused)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SETUP, SHIFT: begin
          if (!half_end_c) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            if (rise_c) begin
              state   <= SHIFT;
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (fall_c) begin
              sclk <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!half_end_c) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            state   <= DONE;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default 8-bit/div-2 instance plus a 16-bit/div-1 instance.
module tb_spi_controller;

  localparam int W1 = 8;
  localparam int W2 = 16;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          start, start2;
  logic [W1-1:0] tx_data, rx_data, reply;
  logic [W2-1:0] tx_data2, rx_data2, reply2;
  logic          busy, done, sclk, cs_n, mosi, miso;
  logic          busy2, done2, sclk2, cs_n2, mosi2, miso2;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int srv_cnt = 0;
  int srv2_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller #(.WIDTH(W1), .CLK_DIV(2)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_controller #(.WIDTH(W2), .CLK_DIV(1)) dut2 (
    .clk(clk), .clear_n(clear_n), .start(start2), .tx_data(tx_data2),
    .busy(busy2), .done(done2), .rx_data(rx_data2), .sclk(sclk2),
    .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
  );

  // Mode-0 servants: bit index advances on falling sclk, resets when deselected
  always @(negedge sclk or posedge cs_n)
    if (cs_n) srv_cnt <= 0; else srv_cnt <= srv_cnt + 1;
  assign miso = (srv_cnt < W1) ? reply[W1-1-srv_cnt] : 1'b0;

  always @(negedge sclk2 or posedge cs_n2)
    if (cs_n2) srv2_cnt <= 0; else srv2_cnt <= srv2_cnt + 1;
  assign miso2 = (srv2_cnt < W2) ? reply2[W2-1-srv2_cnt] : 1'b0;

  typedef struct {
    logic [7:0] bits;
    int         rises;
    int         low;
  } frame_t;

  frame_t     frames[$];
  int         done_cyc[$];
  logic       sclk_q = 1'b0;
  logic       cs_q = 1'b1;
  logic       cs2_q = 1'b1;
  logic [7:0] bits_sh = '0;
  int         rises = 0, low_run = 0, high_run = 0, last_high = 0;
  int         low_run2 = 0, last_low2 = 0;

  // Frame monitor: mosi at each sclk rise, cs_n run lengths, done timestamps
  always @(negedge clk) begin
    frame_t f;
    if (sclk && !sclk_q) begin
      bits_sh = {bits_sh[6:0], mosi};
      rises++;
    end
    if (!cs_n) begin
      if (cs_q) last_high = high_run;
      high_run = 0;
      low_run++;
    end else begin
      if (!cs_q) begin
        f.bits  = bits_sh;
        f.rises = rises;
        f.low   = low_run;
        frames.push_back(f);
      end
      low_run = 0;
      rises = 0;
      high_run++;
    end
    if (done) done_cyc.push_back(cyc);
    if (!cs_n2) low_run2++;
    else begin
      if (!cs2_q) last_low2 = low_run2;
      low_run2 = 0;
    end
    sclk_q = sclk;
    cs_q   = cs_n;
    cs2_q  = cs_n2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, output int seen);
    int k;
    k = 0;
    seen = -1;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (done) seen = cyc;
    else check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int st, dc, dc2, k, r;
    logic prev;

    // Reset held with start asserted
    clear_n = 1'b0; start = 1'b1; start2 = 1'b0;
    tx_data = 8'h5A; tx_data2 = '0; reply = '0; reply2 = '0;
    tick(3);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rx", 32'(rx_data), 32'h00);
    check_eq("rst_cs_n2", 32'(cs_n2), 32'd1);
    start = 1'b0; clear_n = 1'b1;
    tick(2);

    // Single frame 0xA5 out, servant replies 0x3C
    frames.delete(); done_cyc.delete();
    reply = 8'h3C; tx_data = 8'hA5; start = 1'b1; st = cyc + 1;
    tick(1); start = 1'b0;
    check_eq("single_busy", 32'(busy), 32'd1);
    wait_done("single_done_timeout", dc);
    if (dc >= 0) begin
      check_eq("single_latency", 32'(dc - st + 1), 32'd37);
      check_eq("single_rx", 32'(rx_data), 32'h3C);
    end
    tick(1);
    check_eq("single_done_width", 32'(done), 32'd0);
    tick(2);
    check_eq("single_frames", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) begin
      check_eq("single_mosi_bits", 32'(frames[0].bits), 32'hA5);
      check_eq("single_rises", 32'(frames[0].rises), 32'd8);
      check_eq("single_cs_low", 32'(frames[0].low), 32'd36);
    end

    // Back-to-back with start held: 0xFF then 0x01
    frames.delete(); done_cyc.delete();
    reply = 8'h5A; tx_data = 8'hFF; start = 1'b1;
    tick(1); tx_data = 8'h01;
    wait_done("b2b_done1_timeout", dc);
    tick(1); start = 1'b0;
    wait_done("b2b_done2_timeout", dc2);
    if (dc2 >= 0) check_eq("b2b_rx", 32'(rx_data), 32'h5A);
    tick(3);
    check_eq("b2b_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) check_eq("b2b_interval", 32'(done_cyc[1] - done_cyc[0]), 32'd37);
    check_eq("b2b_cs_high", 32'(last_high), 32'd1);
    check_eq("b2b_frames", 32'(frames.size()), 32'd2);
    if (frames.size() == 2) begin
      check_eq("b2b_bits1", 32'(frames[0].bits), 32'hFF);
      check_eq("b2b_bits2", 32'(frames[1].bits), 32'h01);
    end

    // Start pulse with 0x00 during a 0x81 frame is ignored
    frames.delete(); done_cyc.delete();
    reply = 8'h77; tx_data = 8'h81; start = 1'b1;
    tick(1); start = 1'b0;
    tick(9); start = 1'b1; tx_data = 8'h00;
    tick(1); start = 1'b0;
    wait_done("ign_done_timeout", dc);
    if (dc >= 0) check_eq("ign_rx", 32'(rx_data), 32'h77);
    tick(50);
    check_eq("ign_done_count", 32'(done_cyc.size()), 32'd1);
    check_eq("ign_frames", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) check_eq("ign_bits", 32'(frames[0].bits), 32'h81);
    check_eq("ign_cs_n", 32'(cs_n), 32'd1);
    check_eq("ign_busy", 32'(busy), 32'd0);

    // Reset after the 4th sclk rise discards the frame
    frames.delete(); done_cyc.delete();
    reply = 8'h0F; tx_data = 8'hC3; start = 1'b1;
    tick(1); start = 1'b0;
    k = 0; r = 0; prev = sclk;
    while (r < 4 && k < 100) begin
      tick(1); k++;
      if (sclk && !prev) r++;
      prev = sclk;
    end
    check_eq("mid_rises_reached", 32'(r), 32'd4);
    clear_n = 1'b0;
    tick(1);
    check_eq("mid_cs_n", 32'(cs_n), 32'd1);
    check_eq("mid_sclk", 32'(sclk), 32'd0);
    check_eq("mid_mosi", 32'(mosi), 32'd0);
    check_eq("mid_rx", 32'(rx_data), 32'h00);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done), 32'd0);
    clear_n = 1'b1;
    tick(40);
    check_eq("mid_no_done", 32'(done_cyc.size()), 32'd0);

    // 16-bit, CLK_DIV=1 instance sends 0xBEEF
`ifdef MINI_SPI_LOOPBACK_EN
    reply2 = 16'h0000;
`else
    reply2 = 16'hBEEF;
`endif
    tx_data2 = 16'hBEEF; start2 = 1'b1; st = cyc + 1;
    tick(1); start2 = 1'b0;
    k = 0;
    while (!done2 && k < 100) begin
      tick(1); k++;
    end
    check_eq("w16_done_seen", 32'(done2), 32'd1);
    if (done2) begin
      check_eq("w16_latency", 32'(cyc - st + 1), 32'd35);
      check_eq("w16_rx", 32'(rx_data2), 32'hBEEF);
    end
    tick(2);
    check_eq("w16_cs_low", 32'(last_low2), 32'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
